// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
//   AES_LATENCY : issue-to-output latency of the aes_128 pipeline
//   TAG_ID_W    : storage width of the requester id carried in a tag
//   aes_blk_t   : one 128-bit AES block (plaintext, key or ciphertext)
//   tag_t       : {valid, id} travelling alongside a job in the core
package aes_sched_pkg;

  localparam int AES_LATENCY = 21;
  localparam int TAG_ID_W    = 8;

  typedef logic [127:0] aes_blk_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter. The search starts one past the previous winner
// and wraps modulo NREQ; the first active request found is granted.
//   req    : per-requester request
//   last   : index of the previous winner
//   enable : when low, no grant is produced
//   grant  : one-hot grant, or zero
module aes_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  int unsigned idx;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = 0;
    if (enable) begin
      // Walk the search order backwards so the nearest candidate is the
      // last one written and therefore wins.
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(last) + k) % NREQ;
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Round-robin front end sharing one fully pipelined, non-stallable aes_128
// core between NREQ requesters. Each issued job carries its requester id
// through a tag pipeline matched to the core latency; results land in a
// first-word fall-through FIFO. Jobs are admitted only when a FIFO slot is
// guaranteed for their result (in-flight + buffered < FIFO_DEPTH).
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : per-requester job handshake (ready one-hot)
//   req_state/req_key      : packed plaintext/key, 128 bits per requester
//   core_state/core_key    : to the aes_128 inputs (0 when not issuing)
//   core_out               : aes_128 output, LATENCY cycles after issue
//   rsp_valid/rsp_ready    : result handshake
//   rsp_data/rsp_id        : ciphertext and originating requester
//   busy                   : any job in flight or buffered
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int LATENCY    = AES_LATENCY,
  parameter int FIFO_DEPTH = 32,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*128-1:0] req_state,
  input  logic [NREQ*128-1:0] req_key,
  output aes_blk_t          core_state,
  output aes_blk_t          core_key,
  input  aes_blk_t          core_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output aes_blk_t          rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(LATENCY + 1);

  logic [IDW-1:0]   last_q, last_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  aes_blk_t         data_mem [FIFO_DEPTH];
  logic [IDW-1:0]   id_mem   [FIFO_DEPTH];

  logic             credit_ok, issue, push, pop;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  tag_t             exit_tag;

  // Registered counts only: a pop frees its credit on the following cycle.
  assign credit_ok = (32'(inflight_q) + 32'(fifo_count_q)) < 32'(FIFO_DEPTH);

  aes_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .last   (last_q),
    .enable (credit_ok && !rst),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign issue     = |grant;

  always_comb begin
    grant_id   = '0;
    core_state = '0;
    core_key   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id   = IDW'(i);
        core_state = req_state[i*128 +: 128];
        core_key   = req_key[i*128 +: 128];
      end
    end
  end

  assign exit_tag  = tag_q[LATENCY-1];
  assign push      = exit_tag.valid;
  assign rsp_valid = (fifo_count_q != '0) && !rst;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = data_mem[rd_ptr_q];
  assign rsp_id    = id_mem[rd_ptr_q];
  assign busy      = ((inflight_q != '0) || (fifo_count_q != '0)) && !rst;

  always_comb begin
    last_d         = issue ? grant_id : last_q;
    tag_d[0].valid = issue;
    tag_d[0].id    = TAG_ID_W'(grant_id);
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];

    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real registers do.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= IDW'(NREQ - 1);
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      last_q       <= last_d;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // read after being written, and rsp_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= core_out;
      id_mem[wr_ptr_q]   <= exit_tag.id[IDW-1:0];
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler. A behavioural AES-128 core
// with a LATENCY-deep delay line stands in for aes_128; a job-queue model
// predicts grants, credit, response timing, data and ids every cycle.
module tb_aes_job_scheduler;

  localparam int NREQ       = 2;
  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 32;
  localparam int IDW        = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [127:0]      st [NREQ];
  logic [127:0]      ky [NREQ];
  logic [NREQ*128-1:0] req_state, req_key;
  logic [127:0]      core_state, core_key, core_out;
  logic              rsp_valid, rsp_ready;
  logic [127:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  assign req_state = {st[1], st[0]};
  assign req_key   = {ky[1], ky[0]};

  always #5 clk = ~clk;

  aes_job_scheduler #(
    .NREQ       (NREQ),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_state  (req_state),
    .req_key    (req_key),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] r;
      r = 8'h01;
      for (int e = 0; e < 254; e++) r = gmul(r, 8'(v));
      sbox[v] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                  ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] rc, a0, a1, a2, a3, k0, k1, k2, k3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[c*4+w] = t[((c+w)%4)*4+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
          s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k0 = sbox[k[13]] ^ rc; k1 = sbox[k[14]]; k2 = sbox[k[15]]; k3 = sbox[k[12]];
      k[0] = k[0] ^ k0; k[1] = k[1] ^ k1; k[2] = k[2] ^ k2; k[3] = k[3] ^ k3;
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Stand-in for the aes_128 pipeline: output LATENCY cycles after issue.
  logic [127:0] core_pipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) core_pipe[i] = '0;
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  // ---------------- reference model ----------------
  // Every accepted, not-yet-popped job sits in q in issue order; its result
  // becomes visible LATENCY+1 cycles after the issue cycle.
  typedef struct {
    int           id;
    logic [127:0] data;
    int           rdy;
  } job_t;

  job_t q[$];
  int   m_last = NREQ - 1;
  int   cyc = 0;
  int   n_accept = 0;
  int   n_rsp = 0;
  int   dut_grants[$];
  logic ovf;

  assign ovf = dut.push && !dut.pop && (32'(dut.fifo_count_q) == 32'(FIFO_DEPTH));

  always @(negedge clk) begin
    int   g, n_buf, idx;
    logic exp_rv;
    logic [NREQ-1:0] exp_ready;
    job_t j;
    cyc++;
    if (rsp_valid && rsp_ready) n_rsp++;
    if (req_ready != '0) begin
      n_accept++;
      dut_grants.push_back(req_ready[1] ? 1 : 0);
    end
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_core_state", core_state, 0);
      q.delete();
      m_last = NREQ - 1;
    end else begin
      g = -1;
      if (q.size() < FIFO_DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("core_state", core_state, (g >= 0) ? st[g] : 128'h0);
      check("core_key", core_key, (g >= 0) ? ky[g] : 128'h0);
      exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_data", rsp_data, q[0].data);
        check("rsp_id", rsp_id, q[0].id);
      end
      check("busy", busy, q.size() != 0);
      n_buf = 0;
      foreach (q[i]) if (q[i].rdy <= cyc) n_buf++;
      check("fifo_count", dut.fifo_count_q, n_buf);
      check("overflow", ovf, 0);
      if (exp_rv && rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
        j.id = g; j.data = aes_enc(st[g], ky[g]); j.rdy = cyc + LATENCY + 1;
        q.push_back(j);
        m_last = g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      st[i] = {$urandom, $urandom, $urandom, $urandom};
      ky[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, a0, r0, g0;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    rand_data();
    repeat (3) step();
    rst = 1'b0;

    // FIPS-197 vector from requester 0
    st[0] = 128'h00112233445566778899aabbccddeeff;
    ky[0] = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    w = 1;
    while (!rsp_valid && w < 40) begin step(); w++; end
    check("fips_latency", w, LATENCY + 1);
    check("fips_data", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_id", rsp_id, 0);
    repeat (5) step();

    // Round-robin fairness: both requesters valid for 10 cycles
    g0 = dut_grants.size();
    req_valid = 2'b11;
    repeat (10) begin rand_data(); step(); end
    req_valid = '0;
    check("rr_issue_count", dut_grants.size() - g0, 10);
    for (int i = 1; i < 10; i++)
      if (g0 + i < dut_grants.size())
        check("rr_alternate", dut_grants[g0+i], 1 - dut_grants[g0+i-1]);
    repeat (30) step();

    // Backpressure: consumer stalled, requester 1 always valid
    rsp_ready = 1'b0; req_valid = 2'b10;
    a0 = n_accept;
    repeat (60) begin rand_data(); step(); end
    check("bp_accepts", n_accept - a0, FIFO_DEPTH);
    check("bp_stalled", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    a0 = n_accept;
    check("bp_reaccept_now", req_ready, 2'b10);
    repeat (5) step();
    check("bp_reaccept_one", n_accept - a0, 1);

    // Near-full FIFO with simultaneous push and pop
    req_valid = '0;
    repeat (15) step();
    rsp_ready = 1'b1; req_valid = 2'b11;
    repeat (40) begin rand_data(); step(); end
    req_valid = '0;
    repeat (40) step();

    // Idle gaps with random backpressure
    a0 = n_accept; r0 = n_rsp;
    repeat (200) begin
      rand_data();
      req_valid = ($urandom % 3 == 0) ? 2'b00 : 2'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (60) step();
    check("idle_rsp_count", n_rsp - r0, n_accept - a0);
    check("idle_busy", busy, 0);

    // Reset mid-flight
    req_valid = 2'b11;
    repeat (5) begin rand_data(); step(); end
    req_valid = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);
    rand_data();
    req_valid = 2'b11;
    #1;
    check("post_rst_first_grant", req_ready, 2'b01);
    r0 = n_rsp;
    step();
    req_valid = '0;
    repeat (40) step();
    check("post_rst_rsp_count", n_rsp - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
